hex_display_arbiter: RTL

HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

---
 rtl/hex_display_arbiter_pkg.sv | 11 +
 rtl/hex_display_arbiter_rr_pick3.sv | 18 +
 rtl/hex_display_arbiter.sv | 69 ++++++
 3 files changed

// File: rtl/hex_display_arbiter_pkg.sv
// hex_display_arbiter_pkg: state encoding, requester count and round-robin helpers
package hex_display_arbiter_pkg;
  localparam int N_REQ = 3;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return i == 2'd0 ? 2'd1 : i == 2'd1 ? 2'd2 : 2'd0;
  endfunction
  function automatic logic req_at(input logic [N_REQ-1:0] r, input logic [1:0] i);
    return i == 2'd0 ? r[0] : i == 2'd1 ? r[1] : r[2];
  endfunction
endpackage

// File: rtl/hex_display_arbiter_rr_pick3.sv
// rr_pick3: combinational round-robin pick among 3 requesters
// Ports: req[2:0] requests, last[1:0] previous owner;
//        valid (any request), idx[1:0] winner searched from last+1 with wrap 2->0
module rr_pick3
  import hex_display_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic             valid,
  output logic [1:0]       idx
);
  logic [1:0] w_s0, w_s1, w_s2;
  assign w_s0  = rr_next(last);
  assign w_s1  = rr_next(w_s0);
  assign w_s2  = rr_next(w_s1);
  assign valid = |req;
  assign idx   = req_at(req, w_s0) ? w_s0 : req_at(req, w_s1) ? w_s1 : w_s2;
endmodule

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: time-sliced round-robin ownership of a shared 4-digit hex display
// Ports: clk, rst_n (sync, active-low); req[2:0] level requests; data0..2 offered values;
//        grant one-hot owner (0 when idle); disp_data to display driver; owner last/current index;
//        busy high while holding
module hex_display_arbiter
  import hex_display_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [15:0]      data0,
  input  logic [15:0]      data1,
  input  logic [15:0]      data2,
  output logic [N_REQ-1:0] grant,
  output logic [15:0]      disp_data,
  output logic [1:0]       owner,
  output logic             busy
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_grant;
  logic [15:0]      r_disp;
  logic [1:0]       r_owner;
  logic             w_valid, w_expired;
  logic [1:0]       w_idx;
  logic [15:0]      w_win_data, w_own_data;
  rr_pick3 u_pick (
    .req  (req),
    .last (r_owner),
    .valid(w_valid),
    .idx  (w_idx)
  );
  assign w_win_data = w_idx == 2'd0 ? data0 : w_idx == 2'd1 ? data1 : data2;
  assign w_own_data = r_owner == 2'd0 ? data0 : r_owner == 2'd1 ? data1 : data2;
  assign w_expired  = r_cnt == CW'(HOLD_CYCLES);
  // IDLE and hold expiry share one decision; at expiry the search starts after the
  // owner, so the owner is only re-granted when nobody else is requesting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_disp  <= '0;
      r_owner <= 2'd2;
    end else if (r_state == IDLE || w_expired) begin
      if (w_valid) begin
        r_state <= HOLD;
        r_cnt   <= CW'(1);
        r_grant <= N_REQ'(1) << w_idx;
        r_owner <= w_idx;
        r_disp  <= w_win_data;
      end else begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_grant <= '0;
      end
    end else begin
      r_cnt <= r_cnt + CW'(1);
      if (req_at(req, r_owner)) r_disp <= w_own_data;
    end
  end
  assign grant     = r_grant;
  assign disp_data = r_disp;
  assign owner     = r_owner;
  assign busy      = r_state == HOLD;
endmodule
